// File: rtl/ext_pipe_if.sv
// rtl/ext_pipe_if.sv - operand in/out handshake bundle for ext_pipe (EXT_ILLEGAL_CHK_EN adds illegal/sticky flags)
interface ext_pipe_if #(
  parameter int IW   = 16,
  parameter int DW   = 32,
  parameter int TAGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [IW-1:0]   in_imm;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [TAGW-1:0] out_tag;
`ifdef EXT_ILLEGAL_CHK_EN
  logic            out_illegal;
  logic            err_sticky;
`endif

  modport master (
    output in_valid, in_op, in_imm, in_tag, out_ready,
`ifdef EXT_ILLEGAL_CHK_EN
    input  out_illegal, err_sticky,
`endif
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_tag, out_ready,
`ifdef EXT_ILLEGAL_CHK_EN
    output out_illegal, err_sticky,
`endif
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered immediate/sub-word extender with 2-entry skid buffer
// Optional reserved-op flagging enabled by defining EXT_ILLEGAL_CHK_EN.
module ext_pipe #(
  parameter int IW    = 16,
  parameter int DW    = 32,
  parameter int SHAMT = 2,
  parameter int TAGW  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  ext_pipe_if.slave    bus
);

  logic [DW-1:0]   ext_res;
  logic            ext_ill;

  logic            main_valid;
  logic [DW-1:0]   main_data;
  logic [TAGW-1:0] main_tag;
  logic            main_ill;
  logic            skid_valid;
  logic [DW-1:0]   skid_data;
  logic [TAGW-1:0] skid_tag;
  logic            skid_ill;
  logic            in_ready_r;
  logic            skid_valid_nxt;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.in_valid & in_ready_r;
  assign out_xfer = main_valid & bus.out_ready;
  assign ext_ill  = (bus.in_op[2:1] == 2'b11);

  // Shift-based forms stay legal when DW-IW or SHAMT is zero.
  always_comb begin
    ext_res = '0;
    case (bus.in_op)
      3'd0:    ext_res = DW'($signed(bus.in_imm));
      3'd1:    ext_res = DW'(bus.in_imm);
      3'd2:    ext_res = DW'(bus.in_imm) << (DW - IW);
      3'd3:    ext_res = DW'($signed(bus.in_imm)) << SHAMT;
      3'd4:    ext_res = DW'($signed(bus.in_imm[7:0]));
      3'd5:    ext_res = DW'(bus.in_imm[7:0]);
      default: ext_res = '0;
    endcase
  end

  always_comb begin
    skid_valid_nxt = skid_valid;
    if (out_xfer && skid_valid)
      skid_valid_nxt = in_xfer;
    else if (main_valid && !out_xfer && in_xfer)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      main_ill   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      skid_ill   <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      skid_valid <= skid_valid_nxt;
      in_ready_r <= !skid_valid_nxt;
      if (out_xfer && skid_valid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
        main_ill  <= skid_ill;
        if (in_xfer) begin
          skid_data <= ext_res;
          skid_tag  <= bus.in_tag;
          skid_ill  <= ext_ill;
        end
      end else if (!main_valid || out_xfer) begin
        main_valid <= in_xfer;
        if (in_xfer) begin
          main_data <= ext_res;
          main_tag  <= bus.in_tag;
          main_ill  <= ext_ill;
        end
      end else if (in_xfer) begin
        skid_data <= ext_res;
        skid_tag  <= bus.in_tag;
        skid_ill  <= ext_ill;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_tag   = main_tag;

`ifdef EXT_ILLEGAL_CHK_EN
  logic err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_r <= 1'b0;
    else if (in_xfer && ext_ill)
      err_r <= 1'b1;
  end

  assign bus.out_illegal = main_ill;
  assign bus.err_sticky  = err_r;
`else
  logic unused_ill;
  assign unused_ill = main_ill ^ ext_ill;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe
`timescale 1ns/1ps
module tb_ext_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_pipe_if #(.IW(16), .DW(32), .TAGW(5)) bus();

  ext_pipe #(.IW(16), .DW(32), .SHAMT(2), .TAGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] imm, input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_imm   = imm;
    bus.in_tag   = tag;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h expected 00000000", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd0) begin errors++; $display("FAIL reset out_tag: got %0d expected 0", bus.out_tag); end
`ifdef EXT_ILLEGAL_CHK_EN
    checks++; if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL reset err_sticky: got %b expected 0", bus.err_sticky); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_modes();
    logic [2:0]  ops  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd3, 3'd4};
    logic [15:0] imms [10] = '{16'h8001, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'h0080, 16'h0080,
                               16'h1234, 16'h7FFF, 16'h4000, 16'h007F};
    logic [31:0] exps [10] = '{32'hFFFF8001, 32'h0000FFFE, 32'hFFFE0000, 32'hFFFFFFF8, 32'hFFFFFF80,
                               32'h00000080, 32'h00000000, 32'h00007FFF, 32'h00010000, 32'h0000007F};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, ops[i], imms[i], 5'(i + 3));
      @(negedge clk);
      drive(1'b0, 3'd0, 16'h0, 5'd0);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mode[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== exps[i]) begin errors++; $display("FAIL mode[%0d] op%0d out_data: got %h expected %h", i, ops[i], bus.out_data, exps[i]); end
      checks++; if (bus.out_tag !== 5'(i + 3)) begin errors++; $display("FAIL mode[%0d] out_tag: got %0d expected %0d", i, bus.out_tag, i + 3); end
`ifdef EXT_ILLEGAL_CHK_EN
      checks++; if (bus.out_illegal !== (ops[i] >= 3'd6)) begin errors++; $display("FAIL mode[%0d] out_illegal: got %b expected %b", i, bus.out_illegal, ops[i] >= 3'd6); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d] out_valid: got %b expected 1", i - 1, bus.out_valid); end
        checks++; if (bus.out_data !== 32'h1000 + 32'(i - 1)) begin errors++; $display("FAIL b2b[%0d] out_data: got %h expected %h", i - 1, bus.out_data, 32'h1000 + 32'(i - 1)); end
        checks++; if (bus.out_tag !== 5'(i - 1)) begin errors++; $display("FAIL b2b[%0d] out_tag: got %0d expected %0d", i - 1, bus.out_tag, i - 1); end
      end
      if (i < 8) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] in_ready: got %b expected 1", i, bus.in_ready); end
        drive(1'b1, 3'd1, 16'h1000 + 16'(i), 5'(i));
      end else begin
        drive(1'b0, 3'd0, 16'h0, 5'd0);
      end
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b drained out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h1007) begin errors++; $display("FAIL b2b hold out_data: got %h expected 00001007", bus.out_data); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 3'd1, 16'h00A1, 5'd1);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall in_ready n1: got %b expected 1", bus.in_ready); end
    drive(1'b1, 3'd1, 16'h00B2, 5'd2);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready full: got %b expected 0", bus.in_ready); end
    drive(1'b1, 3'd1, 16'h00C3, 5'd3);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready held: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00A1 || bus.out_tag !== 5'd1) begin
      errors++; $display("FAIL stall stable A: got v=%b d=%h t=%0d expected v=1 d=000000a1 t=1", bus.out_valid, bus.out_data, bus.out_tag); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00B2 || bus.out_tag !== 5'd2) begin
      errors++; $display("FAIL stall drain B: got v=%b d=%h t=%0d expected v=1 d=000000b2 t=2", bus.out_valid, bus.out_data, bus.out_tag); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall in_ready reopen: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00C3 || bus.out_tag !== 5'd3) begin
      errors++; $display("FAIL stall drain C: got v=%b d=%h t=%0d expected v=1 d=000000c3 t=3", bus.out_valid, bus.out_data, bus.out_tag); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall empty out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 3'd0, 16'h0011, 5'd7);
    @(negedge clk);
    drive(1'b1, 3'd0, 16'h0022, 5'd8);
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid full: got v=%b rdy=%b expected v=1 rdy=0", bus.out_valid, bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid async out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid async in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid release: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rstmid out_data: got %h expected 00000000", bus.out_data); end
  endtask

`ifdef EXT_ILLEGAL_CHK_EN
  task automatic test_illegal();
    test_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'd7, 16'h1234, 5'd9);
    @(negedge clk);
    drive(1'b1, 3'd0, 16'h0005, 5'd10);
    checks++; if (bus.out_data !== 32'h0 || bus.out_illegal !== 1'b1) begin
      errors++; $display("FAIL illegal op7: got d=%h ill=%b expected d=00000000 ill=1", bus.out_data, bus.out_illegal); end
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL illegal sticky set: got %b expected 1", bus.err_sticky); end
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    checks++; if (bus.out_data !== 32'h5 || bus.out_illegal !== 1'b0) begin
      errors++; $display("FAIL illegal legal-after: got d=%h ill=%b expected d=00000005 ill=0", bus.out_data, bus.out_illegal); end
    checks++; if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL illegal sticky hold: got %b expected 1", bus.err_sticky); end
    test_reset();
  endtask
`endif

  initial begin
    test_reset();
`ifdef EXT_ILLEGAL_CHK_EN
    test_illegal();
`endif
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
